// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - shared types and codes for the memory-stage data-bus initiator
package mem_access_unit_pkg;

  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  typedef enum logic [3:0] {
    MOP_NONE = 4'd0,
    MOP_LB   = 4'd1,
    MOP_LBU  = 4'd2,
    MOP_LH   = 4'd3,
    MOP_LHU  = 4'd4,
    MOP_LW   = 4'd5,
    MOP_SB   = 4'd6,
    MOP_SH   = 4'd7,
    MOP_SW   = 4'd8
  } mem_op_t;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2
  } msize_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } mau_state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    msize_t      size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;

  function automatic logic op_is_store(mem_op_t op);
    return (op == MOP_SB) || (op == MOP_SH) || (op == MOP_SW);
  endfunction

endpackage

// File: rtl/mau_req_gen.sv
// rtl/mau_req_gen.sv - combinational op/addr/wdata to bus size, strobe, lane data and misalignment
module mau_req_gen
  import mem_access_unit_pkg::*;
(
  input  mem_op_t     op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output msize_t      size,
  output logic [3:0]  strobe,
  output logic [31:0] data,
  output logic        misalign,
  output logic        store
);

  always_comb begin
    size     = MSIZE1;
    strobe   = 4'h0;
    data     = 32'h0;
    misalign = 1'b0;
    store    = op_is_store(op);
    case (op)
      MOP_LH, MOP_LHU: begin
        size     = MSIZE2;
        misalign = addr_lo[0];
      end
      MOP_LW: begin
        size     = MSIZE4;
        misalign = |addr_lo;
      end
      MOP_SB: begin
        strobe = 4'b0001 << addr_lo;
        data   = {4{wdata[7:0]}};
      end
      MOP_SH: begin
        size     = MSIZE2;
        misalign = addr_lo[0];
        strobe   = 4'b0011 << {addr_lo[1], 1'b0};
        data     = {2{wdata[15:0]}};
      end
      MOP_SW: begin
        size     = MSIZE4;
        misalign = |addr_lo;
        strobe   = 4'hF;
        data     = wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - memory-stage data-bus initiator with addr_ok/data_ok handshake and AdEL/AdES
module mem_access_unit
  import mem_access_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  mem_op_t     in_op,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic        flush,
  output dbus_req_t   dreq,
  input  dbus_resp_t  dresp,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        exc_valid,
  output logic [4:0]  exc_code,
  output logic [31:0] badvaddr
);

  mau_state_t  state, state_next;
  logic        drop;
  logic        is_load_q;
  logic        accept;
  logic        finish;
  msize_t      gen_size;
  logic [3:0]  gen_strobe;
  logic [31:0] gen_data;
  logic        gen_misalign;
  logic        gen_store;

  mau_req_gen u_req_gen (
    .op       (in_op),
    .addr_lo  (in_addr[1:0]),
    .wdata    (in_wdata),
    .size     (gen_size),
    .strobe   (gen_strobe),
    .data     (gen_data),
    .misalign (gen_misalign),
    .store    (gen_store)
  );

  assign busy = (state != S_IDLE);

  always_comb begin
    state_next = state;
    accept     = (state == S_IDLE) && in_valid && (in_op != MOP_NONE) && !flush;
    finish     = 1'b0;
    case (state)
      S_IDLE: if (accept && !gen_misalign) state_next = S_REQ;
      S_REQ: begin
        if (dresp.addr_ok) begin
          finish     = dresp.data_ok;
          state_next = dresp.data_ok ? S_IDLE : S_WAIT;
        end
      end
      S_WAIT: begin
        // data_ok is only meaningful once the address phase has been taken
        if (dresp.data_ok) begin
          finish     = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      dreq      <= '0;
      done      <= 1'b0;
      rdata     <= 32'h0;
      exc_valid <= 1'b0;
      exc_code  <= 5'h0;
      badvaddr  <= 32'h0;
      drop      <= 1'b0;
      is_load_q <= 1'b0;
    end else begin
      state     <= state_next;
      done      <= 1'b0;
      rdata     <= 32'h0;
      exc_valid <= 1'b0;
      exc_code  <= 5'h0;
      badvaddr  <= 32'h0;
      if (accept && gen_misalign) begin
        exc_valid <= 1'b1;
        exc_code  <= gen_store ? EXC_ADES : EXC_ADEL;
        badvaddr  <= in_addr;
      end
      if (accept && !gen_misalign) begin
        dreq      <= '{valid: 1'b1, addr: in_addr, size: gen_size,
                       strobe: gen_strobe, data: gen_data};
        is_load_q <= !gen_store;
        drop      <= 1'b0;
      end
      if ((state == S_REQ) && dresp.addr_ok) dreq <= '0;
      if (busy && flush) drop <= 1'b1;
      // a flush landing on the completion cycle squashes the result just like an earlier one
      if (finish) begin
        drop <= 1'b0;
        if (!drop && !flush) begin
          done  <= 1'b1;
          rdata <= is_load_q ? dresp.data : 32'h0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  mem_op_t     in_op;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic        flush;
  dbus_req_t   dreq;
  dbus_resp_t  dresp;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] badvaddr;

  int n_pass  = 0;
  int n_total = 0;

  mem_access_unit dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_op     (in_op),
    .in_addr   (in_addr),
    .in_wdata  (in_wdata),
    .flush     (flush),
    .dreq      (dreq),
    .dresp     (dresp),
    .busy      (busy),
    .done      (done),
    .rdata     (rdata),
    .exc_valid (exc_valid),
    .exc_code  (exc_code),
    .badvaddr  (badvaddr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  function automatic int op_bytes(mem_op_t op);
    case (op)
      MOP_LB, MOP_LBU, MOP_SB: return 1;
      MOP_LH, MOP_LHU, MOP_SH: return 2;
      default:                 return 4;
    endcase
  endfunction

  function automatic bit op_store(mem_op_t op);
    return (op == MOP_SB) || (op == MOP_SH) || (op == MOP_SW);
  endfunction

  // transaction-level reference: one op in flight, tracked by phase flags
  bit          m_pending, m_addr_done, m_load, m_drop;
  logic [31:0] m_addr, m_data;
  logic [1:0]  m_size;
  logic [3:0]  m_strobe;
  bit          e_busy, e_valid, e_done, e_exc;
  logic [31:0] e_rdata, e_bad;
  logic [4:0]  e_code;

  always @(posedge clk) begin
    int w;
    e_done = 0; e_rdata = 0; e_exc = 0; e_code = 0; e_bad = 0;
    if (reset) begin
      m_pending = 0; m_addr_done = 0; m_drop = 0;
    end else if (!m_pending) begin
      if (in_valid && in_op != MOP_NONE && !flush) begin
        w = op_bytes(in_op);
        if (in_addr % w != 0) begin
          e_exc  = 1;
          e_code = op_store(in_op) ? 5'd5 : 5'd4;
          e_bad  = in_addr;
        end else begin
          m_pending = 1; m_addr_done = 0; m_drop = 0;
          m_load   = !op_store(in_op);
          m_addr   = in_addr;
          m_size   = (w == 1) ? 2'd0 : (w == 2) ? 2'd1 : 2'd2;
          m_strobe = op_store(in_op) ? 4'(((1 << w) - 1) << (in_addr % 4)) : 4'h0;
          if (!op_store(in_op))  m_data = 0;
          else if (w == 1)       m_data = (in_wdata & 32'hFF) * 32'h01010101;
          else if (w == 2)       m_data = (in_wdata & 32'hFFFF) * 32'h00010001;
          else                   m_data = in_wdata;
        end
      end
    end else begin
      bit fin;
      fin = 0;
      if (flush) m_drop = 1;
      if (!m_addr_done) begin
        if (dresp.addr_ok) begin
          m_addr_done = 1;
          fin = dresp.data_ok;
        end
      end else begin
        fin = dresp.data_ok;
      end
      if (fin) begin
        m_pending = 0;
        if (!m_drop) begin
          e_done  = 1;
          e_rdata = m_load ? dresp.data : 32'h0;
        end
      end
    end
    e_busy  = m_pending;
    e_valid = m_pending && !m_addr_done;
    #1;
    chk("busy", 32'(busy), 32'(e_busy));
    chk("dreq_valid", 32'(dreq.valid), 32'(e_valid));
    chk("done", 32'(done), 32'(e_done));
    chk("rdata", rdata, e_rdata);
    chk("exc_valid", 32'(exc_valid), 32'(e_exc));
    chk("exc_code", 32'(exc_code), 32'(e_code));
    chk("badvaddr", badvaddr, e_bad);
    if (e_valid) begin
      chk("dreq_addr", dreq.addr, m_addr);
      chk("dreq_size", 32'(dreq.size), 32'(m_size));
      chk("dreq_strobe", 32'(dreq.strobe), 32'(m_strobe));
      chk("dreq_data", dreq.data, m_data);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_op(input mem_op_t op, input logic [31:0] a, input logic [31:0] wd);
    in_valid = 1'b1; in_op = op; in_addr = a; in_wdata = wd;
  endtask

  task automatic set_resp(input logic aok, input logic dok, input logic [31:0] d);
    dresp = '{addr_ok: aok, data_ok: dok, data: d};
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_op = MOP_NONE; in_addr = 0; in_wdata = 0; flush = 1'b0;
    set_resp(1'b0, 1'b0, 32'h0);
    tick();
    chk("rst_dreq_zero", 32'(dreq == '0), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    tick();

    // SB to top byte lane, zero-wait bus
    set_op(MOP_SB, 32'h1003, 32'h000000AB);
    set_resp(1'b1, 1'b1, 32'h12345678);
    tick();
    in_valid = 1'b0;
    chk("t1_strobe", 32'(dreq.strobe), 32'h8);
    chk("t1_data", dreq.data, 32'hABABABAB);
    chk("t1_done_early", 32'(done), 32'd0);
    tick();
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_rdata", rdata, 32'h0);
    set_resp(1'b0, 1'b0, 32'h0);
    tick();

    // LW with slow address and data phases
    set_op(MOP_LW, 32'h2000, 32'h0);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t2_busy", 32'(busy), 32'd1);
      chk("t2_valid", 32'(dreq.valid), 32'd1);
      if (i == 2) set_resp(1'b1, 1'b0, 32'h0);
      tick();
    end
    set_resp(1'b0, 1'b0, 32'h0);
    chk("t2_wait_valid", 32'(dreq.valid), 32'd0);
    tick();
    set_resp(1'b0, 1'b1, 32'hDEADBEEF);
    tick();
    set_resp(1'b0, 1'b0, 32'h0);
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_rdata", rdata, 32'hDEADBEEF);
    tick();

    // misaligned SH then misaligned LHU issued on the exception cycle
    set_op(MOP_SH, 32'h3001, 32'h5555);
    tick();
    chk("t3_no_req", 32'(dreq.valid), 32'd0);
    chk("t3_exc", 32'(exc_valid), 32'd1);
    chk("t3_code", 32'(exc_code), 32'd5);
    chk("t3_bad", badvaddr, 32'h3001);
    set_op(MOP_LHU, 32'h3003, 32'h0);
    tick();
    in_valid = 1'b0;
    chk("t3_code2", 32'(exc_code), 32'd4);
    chk("t3_bad2", badvaddr, 32'h3003);
    tick();

    // flush while the LB request is outstanding
    set_op(MOP_LB, 32'h40, 32'h0);
    tick();
    in_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t4_valid_held", 32'(dreq.valid), 32'd1);
    tick();
    set_resp(1'b1, 1'b1, 32'h55);
    tick();
    set_resp(1'b0, 1'b0, 32'h0);
    chk("t4_no_done", 32'(done), 32'd0);
    chk("t4_idle", 32'(busy), 32'd0);
    tick();

    // back-to-back SW then LH accepted on the done cycle
    set_resp(1'b1, 1'b1, 32'hCAFE1234);
    set_op(MOP_SW, 32'h10, 32'h11223344);
    tick();
    in_valid = 1'b0;
    chk("t5_sw_strobe", 32'(dreq.strobe), 32'hF);
    tick();
    chk("t5_sw_done", 32'(done), 32'd1);
    set_op(MOP_LH, 32'h12, 32'h0);
    tick();
    in_valid = 1'b0;
    chk("t5_lh_valid", 32'(dreq.valid), 32'd1);
    chk("t5_lh_size", 32'(dreq.size), 32'(MSIZE2));
    chk("t5_lh_strobe", 32'(dreq.strobe), 32'h0);
    tick();
    chk("t5_lh_rdata", rdata, 32'hCAFE1234);
    set_resp(1'b0, 1'b0, 32'h0);
    tick();

    // reset during the data phase
    set_op(MOP_LW, 32'h50, 32'h0);
    tick();
    in_valid = 1'b0;
    set_resp(1'b1, 1'b0, 32'h0);
    tick();
    set_resp(1'b0, 1'b0, 32'h0);
    reset = 1'b1;
    tick();
    chk("t6_dreq_zero", 32'(dreq == '0), 32'd1);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_done", 32'(done), 32'd0);
    reset = 1'b0;
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
